// File: rtl/spi_cmd_controller.sv
// SPI command decoder and configuration sequencer.
// Turns each new MOSI word into a 4-bit opcode plus 12-bit data, stages
// gain/setpoint writes in shadow registers, commits them atomically and
// gates the controller enable through a link-loss watchdog.
module spi_cmd_controller #(
    parameter int WIDTH     = 16,
    parameter int WD_CYCLES = 1000000
) (
    input  logic             sys_clk,
    input  logic             sys_reset_n,
    input  logic [WIDTH-1:0] mosi_buffer,
    input  logic             mosi_buffer_valid,
    output logic [11:0]      setpoint,
    output logic [7:0]       kp,
    output logic [3:0]       kp_shift,
    output logic             ctrl_enable,
    output logic             cfg_update,
    output logic             cmd_error,
    output logic             wd_trip,
    output logic [7:0]       frame_count
);

    localparam int                WD_W   = (WD_CYCLES > 2) ? $clog2(WD_CYCLES) : 1;
    localparam bit                WD_EN  = (WD_CYCLES > 0);
    localparam logic [WD_W-1:0]   WD_MAX = (WD_CYCLES > 0) ? WD_W'(WD_CYCLES - 1) : '0;

    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_SETPOINT = 4'h1;
    localparam logic [3:0] OP_KP       = 4'h2;
    localparam logic [3:0] OP_SHIFT    = 4'h3;
    localparam logic [3:0] OP_COMMIT   = 4'h4;
    localparam logic [3:0] OP_ENABLE   = 4'h5;
    localparam logic [3:0] OP_CLEAR    = 4'h6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_prev;
    logic [1:0]        r_fill;
    logic              r_armed;
    logic              r_pending;
    logic [WIDTH-1:0]  r_cmd;
    logic [11:0]       r_shadowSetpoint;
    logic [7:0]        r_shadowKp;
    logic [3:0]        r_shadowShift;
    logic [WD_W-1:0]   r_wdCount;

    logic              w_edge;
    logic              w_apply;
    logic              w_dropErr;
    logic              w_wdExpire;
    logic [3:0]        w_opcode;
    logic [11:0]       w_data;

    // r_fill[1] marks the point where sync2 holds a genuinely sampled level,
    // so the reset value of the synchronizer can never arm edge detection.
    assign w_edge     = r_sync2 & ~r_prev & r_armed;
    assign w_apply    = (r_state == ST_DECODE);
    assign w_dropErr  = w_edge & r_pending;
    assign w_opcode   = r_cmd[15:12];
    assign w_data     = r_cmd[11:0];
    assign w_wdExpire = WD_EN && ctrl_enable && (r_wdCount == WD_MAX) && !w_apply;

    // Synchronize the valid level and arm edge detection once it is seen low.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= mosi_buffer_valid;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_fill  <= {r_fill[0], 1'b1};
            if (r_fill[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: IDLE waits for a new or pending frame, then one
    // cycle each in DECODE (apply) and EXEC (commit pulse visible).
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_edge || r_pending) begin
                    w_nextState = ST_DECODE;
                end
            end
            ST_DECODE: w_nextState = ST_EXEC;
            ST_EXEC:   w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    // Latch the command word on leaving IDLE and remember one edge seen while busy.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_cmd     <= '0;
            r_pending <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_edge || r_pending) begin
                r_cmd     <= mosi_buffer;
                r_pending <= 1'b0;
            end
        end else if (w_edge) begin
            r_pending <= 1'b1;
        end
    end

    // Apply the decoded command; otherwise let the watchdog trip the enable.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            setpoint         <= '0;
            kp               <= '0;
            kp_shift         <= '0;
            ctrl_enable      <= 1'b0;
            cfg_update       <= 1'b0;
            cmd_error        <= 1'b0;
            wd_trip          <= 1'b0;
            frame_count      <= '0;
            r_shadowSetpoint <= '0;
            r_shadowKp       <= '0;
            r_shadowShift    <= '0;
        end else begin
            cfg_update <= 1'b0;
            if (w_apply) begin
                frame_count <= frame_count + 8'd1;
                case (w_opcode)
                    OP_NOP: begin
                    end
                    OP_SETPOINT: r_shadowSetpoint <= w_data;
                    OP_KP:       r_shadowKp       <= w_data[7:0];
                    OP_SHIFT:    r_shadowShift    <= w_data[3:0];
                    OP_COMMIT: begin
                        setpoint   <= r_shadowSetpoint;
                        kp         <= r_shadowKp;
                        kp_shift   <= r_shadowShift;
                        cfg_update <= 1'b1;
                    end
                    OP_ENABLE: begin
                        if (wd_trip && w_data[0]) begin
                            ctrl_enable <= 1'b0;
                            cmd_error   <= 1'b1;
                        end else begin
                            ctrl_enable <= w_data[0];
                        end
                    end
                    OP_CLEAR: begin
                        cmd_error <= 1'b0;
                        wd_trip   <= 1'b0;
                    end
                    default: cmd_error <= 1'b1;
                endcase
            end else if (w_wdExpire) begin
                ctrl_enable <= 1'b0;
                wd_trip     <= 1'b1;
            end
            if (w_dropErr) begin
                cmd_error <= 1'b1;
            end
        end
    end

    // Watchdog counter: cleared by every applied frame, otherwise saturating.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_wdCount <= '0;
        end else if (w_apply) begin
            r_wdCount <= '0;
        end else if (r_wdCount != WD_MAX) begin
            r_wdCount <= r_wdCount + 1'b1;
        end
    end

endmodule

// File: doc/spi_cmd_controller.md
Name: spi_cmd_controller

Overview:
- Command decoder and configuration sequencer sitting between spi_mosi_interface and the proportional-controller datapath.
- Detects each newly received MOSI word and decodes it as a 4-bit opcode plus 12-bit data.
- Writes shadow gain/setpoint registers and atomically commits them to the active outputs.
- Gates the controller enable through a link-loss watchdog.

Parameters:
WIDTH, 16, MOSI word width; fixed at 16 (opcode = word[15:12], data = word[11:0]).
WD_CYCLES, 1000000, sys_clk cycles without an executed frame before the watchdog trips; 0 disables the watchdog.

Ports:
sys_clk  input  1  system clock, rising edge.
sys_reset_n  input  1  asynchronous active-low reset.
mosi_buffer  input  WIDTH  received word from spi_mosi_interface; held stable while mosi_buffer_valid is high.
mosi_buffer_valid  input  1  level from spi_mosi_interface, high after a full frame; treated as asynchronous.
setpoint  output  12  active setpoint.
kp  output  8  active proportional gain.
kp_shift  output  4  active gain right-shift.
ctrl_enable  output  1  controller enable.
cfg_update  output  1  one-cycle pulse on commit.
cmd_error  output  1  sticky error flag.
wd_trip  output  1  sticky watchdog-trip flag.
frame_count  output  8  executed-frame counter; wraps 255->0.

Behaviour:
- Reset (asynchronous): all outputs, shadow registers, FSM state, pending bit, synchronizer flops and watchdog counter go to 0.
- Edge detection:
  - mosi_buffer_valid passes through a 2-flop synchronizer (sync1, sync2) and a delay flop (prev); edge = sync2 & ~prev.
  - After reset, edges are ignored until sync2 has been sampled low once (armed bit). A valid level still high across reset is therefore never replayed.
- FSM states: IDLE, DECODE, EXEC.
  - IDLE -> DECODE on edge or on the pending bit; mosi_buffer is latched into cmd and pending is cleared.
  - DECODE -> EXEC unconditionally. All register effects of cmd are applied on this clock edge.
  - EXEC -> IDLE unconditionally. cfg_update is high for exactly the EXEC cycle when the opcode was COMMIT.
- Latency: with valid first sampled high at edge 1, the FSM enters DECODE at edge 3 and outputs change at edge 4.
- Edges arriving while busy:
  - An edge in DECODE/EXEC sets pending; it is served from IDLE on the next edge.
  - An edge while pending is already set is dropped and sets cmd_error.
- Opcodes (cmd[15:12]):
  - 0x0 NOP.
  - 0x1 shadow_setpoint <= data[11:0].
  - 0x2 shadow_kp <= data[7:0].
  - 0x3 shadow_shift <= data[3:0].
  - 0x4 COMMIT: setpoint/kp/kp_shift <= shadow values.
  - 0x5 ENABLE: ctrl_enable <= data[0]. If wd_trip=1 and data[0]=1, enable stays 0 and cmd_error is set.
  - 0x6 CLEAR: cmd_error <= 0, wd_trip <= 0.
  - 0x7-0xF: illegal, sets cmd_error; no other effect.
- Every executed frame, including NOP and illegal opcodes, increments frame_count and clears the watchdog counter.
- Shadow writes never alter the active outputs until a COMMIT executes.
- Watchdog:
  - The counter increments every cycle the FSM is not applying a frame. It saturates at WD_CYCLES-1.
  - When ctrl_enable=1 and the counter equals WD_CYCLES-1, ctrl_enable <= 0 and wd_trip <= 1.
  - If a frame is applied on the same edge, the frame wins: the counter clears and no trip occurs.
  - When WD_CYCLES=0 the watchdog never trips.
- Reset mid-frame: all in-flight state and pending frames are discarded.

Test Plan:
- Reset, then words 0x1123, 0x2040, 0x3004 each with a valid pulse -> setpoint/kp/kp_shift remain 0 and frame_count=3. Then send 0x4000 -> setpoint=0x123, kp=0x40, kp_shift=4, cfg_update high exactly 1 cycle, frame_count=4.
- Valid rises at edge 1 with word 0x5001 -> ctrl_enable=0 through edge 3 and ctrl_enable=1 after edge 4.
- With WD_CYCLES=100 and ctrl_enable=1, send no frames -> wd_trip=1 and ctrl_enable=0 exactly 100 cycles after the last frame's apply edge. Then 0x5001 -> enable stays 0 and cmd_error=1. Then 0x6000 followed by 0x5001 -> ctrl_enable=1, both flags 0.
- Word 0x9ABC -> cmd_error=1, active registers unchanged, frame_count incremented.
- Hold valid high, assert reset for 3 cycles, release -> no frame executes (frame_count=0). Drop valid, raise it with 0x1001 -> shadow setpoint written.
- Send 256 NOP frames -> frame_count wraps back to 0.
